// File: rtl/ascon_bdi_packer_pkg.sv
// Shared config for the Ascon bdi packer: default core word width, segment type codes, packer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ascon_bdi_packer_pkg;

  // Default core word width; the packer also supports 64.
  localparam int CCW_DFLT = 32;

  // Segment type codes carried on in_type / bdi_type.
  localparam logic [3:0] D_NULL  = 4'h0;
  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_MSG   = 4'h4;
  localparam logic [3:0] D_TAG   = 4'h8;

  // Packer accumulator state.
  typedef enum logic [1:0] {
    PK_EMPTY = 2'd0,  // no bytes collected
    PK_FILL  = 2'd1,  // partial word collected
    PK_FULL  = 2'd2   // completed word parked, waiting for the output slot
  } pk_state_e;

endpackage

// File: rtl/ascon_bdi_packer.sv
// Packs a byte-serial tagged stream into CCW-wide bdi words for the Ascon core, with one output slot.
// Latency: 1 cycle from the completing byte to bdi_valid when the slot is free or draining.
// Backpressure: bdi_ready low holds the slot; a second completed word parks in the accumulator and drops in_ready.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_data/in_valid/in_ready        byte stream handshake
//   in_type/in_eot/in_eoi            segment type and end-of-segment / end-of-input markers
//   bdi/bdi_valid/bdi_ready          word, byte mask (contiguous from bit 0, zero = no word), core accept
//   bdi_type/bdi_eot/bdi_eoi         word attributes
//   err                              sticky protocol error (type change mid-word, eoi without eot)
module ascon_bdi_packer
  import ascon_bdi_packer_pkg::*;
#(
  parameter int CCW = CCW_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_type,
  input  logic             in_eot,
  input  logic             in_eoi,
  output logic [CCW-1:0]   bdi,
  output logic [CCW/8-1:0] bdi_valid,
  input  logic             bdi_ready,
  output logic [3:0]       bdi_type,
  output logic             bdi_eot,
  output logic             bdi_eoi,
  output logic             err
);

  localparam int NB = CCW / 8;
  localparam int CW = $clog2(NB) + 1;

  pk_state_e      state, state_nxt;
  logic [CCW-1:0] acc_data;
  logic [NB-1:0]  acc_mask;
  logic [3:0]     acc_type;
  logic           acc_eot, acc_eoi;
  logic [CW-1:0]  byte_cnt;

  logic           slot_free, in_xfer, type_bad, accept, complete;
  logic           load_new, load_acc;
  logic [CCW-1:0] new_data;
  logic [NB-1:0]  new_mask;
  logic [3:0]     new_type;

  // The slot can take a word if it is empty or is being drained this cycle.
  assign slot_free = (bdi_valid == '0) || bdi_ready;
  assign in_xfer   = in_valid && in_ready;
  assign type_bad  = (state == PK_FILL) && (in_type != acc_type);
  assign accept    = in_xfer && !type_bad;
  assign complete  = accept && ((byte_cnt == CW'(NB - 1)) || in_eot || in_eoi);

  // Word as it looks with the incoming byte merged in. The accumulator is
  // zero whenever it is empty, so unused lanes of an emitted word are zero.
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign new_data[8*k +: 8] = (byte_cnt == CW'(k)) ? in_data : acc_data[8*k +: 8];
    assign new_mask[k]        = acc_mask[k] | (byte_cnt == CW'(k));
  end
  assign new_type = (state == PK_EMPTY) ? in_type : acc_type;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PK_EMPTY;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      PK_EMPTY, PK_FILL: begin
        if (complete)    state_nxt = slot_free ? PK_EMPTY : PK_FULL;
        else if (accept) state_nxt = PK_FILL;
      end
      PK_FULL:           if (slot_free) state_nxt = PK_EMPTY;
      default:           state_nxt = PK_EMPTY;
    endcase
  end

  // FSM: outputs / datapath controls
  always_comb begin
    in_ready = 1'b1;
    load_new = 1'b0;
    load_acc = 1'b0;
    case (state)
      PK_FULL: begin
        in_ready = 1'b0;
        load_acc = slot_free;
      end
      default: load_new = complete && slot_free;
    endcase
  end

  // Accumulator. A word completed without a free slot is simply kept here
  // (the accept branch), and the FSM marks it as parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data <= '0;
      acc_mask <= '0;
      acc_type <= D_NULL;
      acc_eot  <= 1'b0;
      acc_eoi  <= 1'b0;
      byte_cnt <= '0;
    end else if (load_new || load_acc) begin
      acc_data <= '0;
      acc_mask <= '0;
      acc_type <= D_NULL;
      acc_eot  <= 1'b0;
      acc_eoi  <= 1'b0;
      byte_cnt <= '0;
    end else if (accept) begin
      acc_data <= new_data;
      acc_mask <= new_mask;
      acc_type <= new_type;
      acc_eot  <= in_eot | in_eoi;
      acc_eoi  <= in_eoi;
      byte_cnt <= byte_cnt + CW'(1);
    end
  end

  // Output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bdi       <= '0;
      bdi_valid <= '0;
      bdi_type  <= D_NULL;
      bdi_eot   <= 1'b0;
      bdi_eoi   <= 1'b0;
    end else if (load_new) begin
      bdi       <= new_data;
      bdi_valid <= new_mask;
      bdi_type  <= new_type;
      bdi_eot   <= in_eot | in_eoi;
      bdi_eoi   <= in_eoi;
    end else if (load_acc) begin
      bdi       <= acc_data;
      bdi_valid <= acc_mask;
      bdi_type  <= acc_type;
      bdi_eot   <= acc_eot;
      bdi_eoi   <= acc_eoi;
    end else if (bdi_ready && (bdi_valid != '0)) begin
      bdi       <= '0;
      bdi_valid <= '0;
      bdi_type  <= D_NULL;
      bdi_eot   <= 1'b0;
      bdi_eoi   <= 1'b0;
    end
  end

  // Sticky error: mismatched type mid-word (byte dropped) or eoi without eot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if ((in_xfer && type_bad) || (accept && in_eoi && !in_eot))
      err <= 1'b1;
  end

endmodule

// File: doc/ascon_bdi_packer.md
Name: ascon_bdi_packer

Overview:
- Upstream neighbour of the Ascon core.
- Converts a byte-serial tagged input stream (nonce, AD, message, tag) into CCW-wide words with a byte-valid mask and eot/eoi flags, matching the core's bdi port.
- Provides one word of output buffering, so byte accumulation continues while the core is busy.
- Sits between the host/byte interface and the core's bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi and bdi_ready signals.

Parameters:
- CCW, 32, core word width in bits; legal values are 32 and 64.
- NB, CCW/8, bytes per word; derived, not overridable.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  input byte.
- in_valid  input  1  input byte valid.
- in_ready  output  1  packer can accept a byte.
- in_type  input  4  segment type (D_NONCE, D_AD, D_MSG, D_TAG).
- in_eot  input  1  last byte of the current type segment.
- in_eoi  input  1  last byte of all input for this operation.
- bdi  output  CCW  packed word; byte k occupies bits [8k+7:8k].
- bdi_valid  output  NB  byte mask, contiguous from bit 0; all-zero means no word.
- bdi_ready  input  1  core accepts the word.
- bdi_type  output  4  type of the word.
- bdi_eot  output  1  word ends its segment.
- bdi_eoi  output  1  word ends the input.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0):
  - bdi=0, bdi_valid=0, bdi_type=D_NULL, bdi_eot=0, bdi_eoi=0, err=0.
  - in_ready=1 once rst_n is released.
  - Accumulator, byte count and FSM return to EMPTY immediately.
  - A partially packed word is discarded; there is no flush.
- Transfer definitions:
  - Input transfer is in_valid && in_ready.
  - Output transfer is (bdi_valid != 0) && bdi_ready.
- Accumulator registers:
  - acc_data[CCW], acc_mask[NB], acc_type, acc_eot, acc_eoi, byte_cnt (clog2(NB)+1 bits).
- Output register:
  - Holds bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi.
  - Occupied iff bdi_valid != 0.
- FSM states:
  - EMPTY: byte_cnt=0, in_ready=1. An input transfer writes byte 0, sets acc_type=in_type, and moves to FILL.
  - FILL: in_ready=1. An input transfer writes byte byte_cnt and sets mask bit byte_cnt.
  - FULL: the accumulator holds a completed word waiting for the output slot; in_ready=0.
- Word completion: the accepted byte is byte NB-1, or in_eot=1, or in_eoi=1.
  - On completion, if the output slot is empty, or an output transfer happens in the same cycle, the word moves into the output register at that edge and the FSM goes to EMPTY. Zero bubble; latency from last byte to bdi_valid is 1 cycle.
  - Otherwise the FSM goes to FULL. It leaves FULL at the first edge where the slot is free or being freed, loads the output register and goes to EMPTY.
- Output register is cleared (bdi_valid=0) on an output transfer with no new word loading in the same cycle.
- A word completed by in_eoi always has eot=1 as well.
- Unused bytes of bdi are 0, not stale data.
- Type mismatch: in FILL, an accepted byte with in_type != acc_type:
  - err is set (sticky until reset) and the byte is dropped.
  - The accumulator is unchanged.
- A byte with in_eoi=1 and in_eot=0 sets err; the word is still emitted with eot=1, eoi=1.
- Output values are stable while bdi_valid != 0 and bdi_ready=0; they change only after an output transfer.
- Peak throughput is 1 byte/cycle. One word is output every NB cycles when the core keeps bdi_ready=1.
- Empty segments are not representable. A zero-length AD or message is signalled by in_eoi on the final byte of the previous segment.

Decomposition:
- Shared package (existing config): CCW, D_NULL/D_NONCE/D_AD/D_MSG/D_TAG codes.
- New in the package: the packer FSM typedef (EMPTY, FILL, FULL).
- Single module, no sub-module. Byte-lane write decoding is an inline generate loop over NB.

Test Plan:
- CCW=32, bytes 01,02,03,04, type D_AD, eot on 04, bdi_ready=1 -> one cycle later bdi=0x04030201, bdi_valid=4'b1111, bdi_eot=1, bdi_eoi=0, bdi_type=D_AD.
- Bytes AA,BB,CC, type D_MSG, eot=1 and eoi=1 on CC -> bdi=0x00CCBBAA, bdi_valid=4'b0111, eot=1, eoi=1.
- 12 consecutive D_MSG bytes, with bdi_ready=0 for the first 10 cycles -> word 1 held stable, word 2 goes to FULL and in_ready=0 after byte 8. After bdi_ready rises: words 1, 2, 3 delivered in order with no loss or duplication.
- D_AD bytes 11,22, then a D_MSG byte 33 without eot -> err=1 and stays 1. Next D_AD byte 44 with eot -> bdi=0x00442211, mask 4'b0111.
- rst_n pulsed low after 2 bytes of a word -> outputs immediately 0 and err=0. Subsequent bytes 05..08 -> bdi=0x08070605 with no residue.
- CCW=64, 16 D_NONCE bytes 00..0F, eot on 0F -> two words, 0x0706050403020100 (eot=0) then 0x0F0E0D0C0B0A0908 (eot=1), each with mask 8'hFF.
